// File: rtl/fifo_ser_pkg.sv
// Shared types and defaults for the FIFO bit serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_ser_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int BIT_PERIOD_DEF = 4;

  // Serializer control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    SHIFT = 2'd3
  } ser_state_e;

endpackage

// File: rtl/ser_bit_timer.sv
// Bit period timer: counts 0..BIT_PERIOD-1 while run is high, flags the final cycle.
// Latency: bit_done_o is combinational from the count and run_i (run_i is state-decoded upstream).
// Backpressure: none; clear_i has priority over run_i and restarts the period at zero.
module ser_bit_timer
  import fifo_ser_pkg::*;
#(
  parameter int BIT_PERIOD = BIT_PERIOD_DEF
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic run_i,
  output logic bit_done_o
);

  localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BIT_PERIOD - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, otherwise advance and wrap at the end of each bit
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (run_i) begin
      count_d = (count_q == LAST_CNT) ? '0 : count_q + CW'(1);
    end
  end

  // Period counter register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bit_done_o = run_i && (count_q == LAST_CNT);

endmodule

// File: rtl/fifo_bit_serializer.sv
// Pops bytes from a registered-read FIFO and shifts them out MSB-first, BIT_PERIOD clocks per bit.
// Latency: start condition at cycle t -> rd_en at t+1, load at t+2, first tx_valid at t+3.
// Backpressure: never reads an empty FIFO; enable only gates new bytes at byte boundaries.
module fifo_bit_serializer
  import fifo_ser_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int BIT_PERIOD  = BIT_PERIOD_DEF,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic                   fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]  fifo_data_i,
  output logic                   fifo_rd_en_o,
  output logic                   tx_bit_o,
  output logic                   tx_valid_o,
  output logic                   tx_first_o,
  output logic                   tx_last_o,
  output logic                   busy_o,
  output logic [COUNT_WIDTH-1:0] bytes_sent_o
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  ser_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [COUNT_WIDTH-1:0] sent_q, sent_d;

  logic start_ok;
  logic shifting;
  logic bit_done;

  // A new byte may only be requested when allowed and data is actually present
  assign start_ok = enable_i && !fifo_empty_i;
  assign shifting = (state_q == SHIFT);

  ser_bit_timer #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_timer (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .clear_i   (state_q == LOAD),
    .run_i     (shifting),
    .bit_done_o(bit_done)
  );

  // Control FSM plus shift register, bit index and byte counter next-state
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    sent_d  = sent_q;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = FETCH;
      end
      FETCH: begin
        // Read strobe is out this cycle; data arrives next cycle
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = fifo_data_i;
        idx_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (bit_done) begin
          shift_d = shift_q << 1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            sent_d  = sent_q + COUNT_WIDTH'(1);
            state_d = start_ok ? FETCH : IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any partially sent byte
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      sent_q  <= sent_d;
    end
  end

  assign fifo_rd_en_o = (state_q == FETCH);
  assign tx_valid_o   = shifting;
  assign tx_bit_o     = shifting && shift_q[DATA_WIDTH-1];
  assign tx_first_o   = shifting && (idx_q == '0);
  assign tx_last_o    = shifting && (idx_q == LAST_IDX);
  assign busy_o       = (state_q != IDLE);
  assign bytes_sent_o = sent_q;

endmodule

// File: tb/tb_fifo_bit_serializer.sv
// Self-checking bench for fifo_bit_serializer with a behavioural registered-read FIFO.
// Latency: n/a.
// Backpressure: n/a.
module tb_fifo_bit_serializer;

  localparam int DW = 8;
  localparam int BP = 4;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en;
  logic          tx_bit, tx_valid, tx_first, tx_last, busy;
  logic [CW-1:0] bytes_sent;

  fifo_bit_serializer #(
    .DATA_WIDTH (DW),
    .BIT_PERIOD (BP),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .enable_i    (enable),
    .fifo_empty_i(fifo_empty),
    .fifo_data_i (fifo_data),
    .fifo_rd_en_o(fifo_rd_en),
    .tx_bit_o    (tx_bit),
    .tx_valid_o  (tx_valid),
    .tx_first_o  (tx_first),
    .tx_last_o   (tx_last),
    .busy_o      (busy),
    .bytes_sent_o(bytes_sent)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- FIFO model with one-cycle registered read ----------------
  logic [DW-1:0] mem [0:127];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  typedef struct packed { logic bt; logic fst; logic lst; } exp_t;
  exp_t exp_q[$];
  exp_t e;

  // Expected bit stream is queued when the FIFO actually hands a byte out
  function automatic void sb_push(input logic [DW-1:0] d);
    for (int b = DW - 1; b >= 0; b--)
      for (int p = 0; p < BP; p++)
        exp_q.push_back('{bt: d[b], fst: (b == DW - 1), lst: (b == 0)});
  endfunction

  always @(posedge clock) begin
    if (fifo_rd_en) begin
      checks++;
      if (wr_ptr == rd_ptr) begin
        errors++;
        $display("FAIL underflow_read actual=rd_en_while_empty required=no_read");
      end else begin
        fifo_data <= mem[rd_ptr];
        sb_push(mem[rd_ptr]);
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  // ---------------- output monitor / scoreboard ----------------
  int       rd_cnt = 0;
  int       last_rd_cyc = 0;
  int       first_valid_cyc = 0;
  int       last_valid_cyc = 0;
  bit       have_fall = 0;
  bit       prev_valid = 0;
  int       vcnt = 0;
  logic [DW-1:0] cap = '0;
  logic [DW-1:0] last_cap = '0;
  int       last_len = 0;
  int       gap_q[$];

  always @(negedge clock) begin
    if (fifo_rd_en) begin
      rd_cnt++;
      last_rd_cyc = cyc;
    end
    if (tx_valid) begin
      if (!prev_valid) begin
        first_valid_cyc = cyc;
        if (have_fall) gap_q.push_back(cyc - last_valid_cyc - 1);
        vcnt = 0;
        cap  = '0;
      end
      if (vcnt % BP == 0) cap = {cap[DW-2:0], tx_bit};
      vcnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra_bit actual=tx_valid_high required=no_pending_bits");
      end else begin
        e = exp_q.pop_front();
        chk("sb_bit", tx_bit, e.bt);
        chk("sb_first", tx_first, e.fst);
        chk("sb_last", tx_last, e.lst);
      end
    end else begin
      chk("idle_bit_first_last", {tx_bit, tx_first, tx_last}, 0);
      if (prev_valid) begin
        last_cap       = cap;
        last_len       = vcnt;
        last_valid_cyc = cyc - 1;
        have_fall      = 1;
      end
    end
    prev_valid = tx_valid;
  end

  // ---------------- bounded waits ----------------
  task automatic wait_done(input int limit, input string name);
    bit seen = 0;
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (busy) seen = 1;
      else if (seen) begin
        ok = 1;
        break;
      end
    end
    #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=timeout required=idle_within_%0d", name, limit);
    end
  endtask

  task automatic wait_first(input int limit, input string name);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (tx_valid && tx_first) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=timeout required=first_bit_within_%0d", name, limit);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, fifo_rd_en, 0);
    chk({tag, "_tx_bit"}, tx_bit, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_first"}, tx_first, 0);
    chk({tag, "_tx_last"}, tx_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_bytes_sent"}, bytes_sent, 0);
  endtask

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] exp_stream;
    logic [CW-1:0] exp_sent;
  } vec_t;

  vec_t vecs [6];

  // ---------------- main sequence ----------------
  initial begin
    int rd0;
    int push_cyc;
    int bad;
    logic [CW-1:0] base;

    vecs[0] = '{din: 8'hA5, exp_stream: 8'hA5, exp_sent: 4'd1};
    vecs[1] = '{din: 8'h00, exp_stream: 8'h00, exp_sent: 4'd2};
    vecs[2] = '{din: 8'hFF, exp_stream: 8'hFF, exp_sent: 4'd3};
    vecs[3] = '{din: 8'h80, exp_stream: 8'h80, exp_sent: 4'd4};
    vecs[4] = '{din: 8'h01, exp_stream: 8'h01, exp_sent: 4'd5};
    vecs[5] = '{din: 8'h3C, exp_stream: 8'h3C, exp_sent: 4'd6};

    // Reset values
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clock);

    // Single-byte transactions from the table
    for (int i = 0; i < 6; i++) begin
      rd0 = rd_cnt;
      push(vecs[i].din);
      push_cyc = cyc;
      wait_done(100, "vec_done");
      chk("vec_stream", last_cap, vecs[i].exp_stream);
      chk("vec_valid_len", last_len, DW * BP);
      chk("vec_rd_pulses", rd_cnt - rd0, 1);
      chk("vec_rd_latency", last_rd_cyc - push_cyc, 1);
      chk("vec_valid_latency", first_valid_cyc - push_cyc, 3);
      chk("vec_bytes_sent", bytes_sent, vecs[i].exp_sent);
      chk("vec_busy_after", busy, 0);
    end

    // Back-to-back bytes with preloaded FIFO
    enable = 1'b0;
    push(8'h05);
    push(8'h06);
    push(8'h07);
    have_fall = 0;
    gap_q.delete();
    rd0 = rd_cnt;
    base = bytes_sent;
    @(negedge clock);
    enable = 1'b1;
    wait_done(300, "b2b_done");
    chk("b2b_rd_pulses", rd_cnt - rd0, 3);
    chk("b2b_bytes_sent", bytes_sent, base + 4'd3);
    chk("b2b_gap_count", gap_q.size(), 2);
    chk("b2b_gap0", (gap_q.size() > 0) ? gap_q[0] : -1, 2);
    chk("b2b_gap1", (gap_q.size() > 1) ? gap_q[1] : -1, 2);
    chk("b2b_last_byte", last_cap, 8'h07);
    chk("b2b_sb_drained", exp_q.size(), 0);

    // Enabled with an empty FIFO
    rd0 = rd_cnt;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (busy || tx_valid) bad++;
    end
    chk("empty_rd_pulses", rd_cnt - rd0, 0);
    chk("empty_busy_or_valid", bad, 0);

    // Enable dropped during bit 3 of the first of two bytes
    enable = 1'b0;
    push(8'hC3);
    push(8'h5A);
    rd0 = rd_cnt;
    @(negedge clock);
    enable = 1'b1;
    wait_first(20, "drop_first");
    repeat (3 * BP) @(negedge clock);
    enable = 1'b0;
    wait_done(100, "drop_done");
    repeat (20) @(negedge clock);
    chk("drop_bytes_sent", bytes_sent, 4'd10);
    chk("drop_rd_pulses", rd_cnt - rd0, 1);
    chk("drop_byte", last_cap, 8'hC3);
    chk("drop_fifo_level", wr_ptr - rd_ptr, 1);
    chk("drop_busy", busy, 0);

    // Reset during bit 5, then restart from the next FIFO byte
    push(8'h96);
    enable = 1'b1;
    wait_first(20, "rst_first");
    repeat (5 * BP + 1) @(negedge clock);
    chk("rst_pre_valid", tx_valid, 1);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clock);
    check_reset_outputs("midreset");
    exp_q.delete();
    chk("midreset_fifo_level", wr_ptr - rd_ptr, 1);
    reset = 1'b0;
    enable = 1'b1;
    wait_done(100, "restart_done");
    chk("restart_byte", last_cap, 8'h96);
    chk("restart_bytes_sent", bytes_sent, 4'd1);

    // Counter wrap: 17 bytes into a 4-bit counter
    enable = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("wrap_start_count", bytes_sent, 0);
    for (int i = 0; i < 17; i++) push(DW'($urandom_range(0, 255)));
    rd0 = rd_cnt;
    @(negedge clock);
    enable = 1'b1;
    wait_done(17 * (DW * BP + 2) + 50, "wrap_done");
    chk("wrap_rd_pulses", rd_cnt - rd0, 17);
    chk("wrap_bytes_sent", bytes_sent, 4'd1);
    chk("wrap_fifo_empty", fifo_empty, 1);
    chk("final_sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=simulation_stalled required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_bit_serializer.md
# fifo_bit_serializer

Read-side consumer for the single-clock byte FIFO. Whenever enabled and the FIFO is non-empty, it pops one byte, then shifts it out MSB-first as a timed bit stream (BIT_PERIOD clocks per bit) toward the tag backscatter encoder. It drives the FIFO read port directly, accounts for the FIFO's one-cycle registered read latency, and never reads an empty FIFO.

## Interface
- DATA_WIDTH, 8: FIFO word width and bits per serialized word.
- BIT_PERIOD, 4: clock cycles each bit is held on tx_bit; legal range ≥1.
- COUNT_WIDTH, 16: width of bytes_sent.
- Clocking: one clock. Reset is synchronous and active-high.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  permits starting a new byte; sampled only at byte boundaries.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO data_out; valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO read_en; single-cycle pulse per byte.
- tx_bit  out  1  current serial bit.
- tx_valid  out  1  tx_bit is meaningful.
- tx_first  out  1  high for all cycles of bit 0 (MSB) of each byte.
- tx_last  out  1  high for all cycles of the final bit (LSB).
- busy  out  1  state ≠ IDLE.
- bytes_sent  out  COUNT_WIDTH  count of fully shifted bytes; wraps modulo 2^COUNT_WIDTH.

## Operation
- States: IDLE, FETCH, LOAD, SHIFT.
- IDLE: if enable && !fifo_empty → FETCH, else stay.
- FETCH: fifo_rd_en=1 for exactly this cycle; → LOAD unconditionally.
- LOAD: shift register ← fifo_data; bit index ← 0; period counter ← 0; → SHIFT.
- SHIFT: tx_valid=1, tx_bit = shift_reg[DATA_WIDTH-1]. Period counter counts 0..BIT_PERIOD-1; on BIT_PERIOD-1 the register shifts left by 1 and the bit index increments.
- End of byte (last cycle of bit DATA_WIDTH-1): bytes_sent += 1; if enable && !fifo_empty → FETCH, else → IDLE.
- enable deasserted mid-byte: the current byte completes; no new fetch.
- fifo_rd_en is asserted only in FETCH, and FETCH is entered only when fifo_empty was sampled low in the same cycle. No underflow reads.
- Reset (any state, any cycle): next state IDLE; shift register, counters, bit index and bytes_sent cleared.
- Outputs are registered or decoded from state only. No combinational path from inputs to outputs.

## Timing
- Reset values: fifo_rd_en=0, tx_bit=0, tx_valid=0, tx_first=0, tx_last=0, busy=0, bytes_sent=0.
- Start latency: if the condition holds in IDLE at cycle t, then fifo_rd_en is high at t+1, LOAD occurs at t+2, and the first tx_valid cycle is t+3.
- Byte duration: DATA_WIDTH*BIT_PERIOD cycles of tx_valid.
- Back-to-back gap: 2 cycles with tx_valid=0 (FETCH, LOAD) between consecutive bytes.
- tx_valid=0 in IDLE, FETCH, LOAD; tx_bit=0 whenever tx_valid=0.
- bytes_sent updates on the clock edge ending the last bit cycle.
- Reset asserted mid-SHIFT: tx_valid=0 in the cycle after the reset edge. The partially sent byte is dropped and not counted.

## Structure
- Shared package fifo_ser_pkg holds:
  - the state enum (IDLE, FETCH, LOAD, SHIFT);
  - default constants DATA_WIDTH_DEF=8 and BIT_PERIOD_DEF=4.
- One sub-module, ser_bit_timer:
  - parameterized BIT_PERIOD period counter;
  - inputs clear and run; output bit_done pulse on count BIT_PERIOD-1.
- FSM, shift register, bit index and byte counter live in the top level.

## Test plan
- Reset, then write 0xA5 to the FIFO, enable=1 → one fifo_rd_en pulse. tx_bit sequence 1,0,1,0,0,1,0,1, each held 4 cycles. tx_first during the first bit, tx_last during the eighth. bytes_sent=1. Returns to IDLE with busy=0.
- Preload 0x05, 0x06, 0x07 and enable → exactly 3 fifo_rd_en pulses, 2-cycle tx_valid gaps between bytes, bytes_sent=3, and no fifo_rd_en while fifo_empty=1.
- enable=1 with the FIFO empty for 100 cycles → fifo_rd_en never asserted, busy=0, tx_valid=0.
- Preload two bytes and deassert enable during bit 3 of the first byte → the first byte completes, the second is not fetched, bytes_sent=1, and the FIFO stays non-empty.
- Assert reset during bit 5 of a byte → the next cycle shows all outputs at reset values and bytes_sent=0. Restarting with enable sends the next FIFO byte from its MSB.
- COUNT_WIDTH=4 with 17 bytes sent → bytes_sent wraps to 1.
